// File: rtl/edge_bit_packer.sv
// Packs Canny edge pixels (nonzero = 1) MSB-first into bytes and queues them for a UART TX stage.
// Define PACK_HEADER_EN to prefix each frame with sync bytes 0xA5, 0x5A.
module edge_bit_packer #(
  parameter int IMG_WIDTH  = 176,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  canny_de,
  input  logic [DATA_WIDTH-1:0] canny_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int TOTAL_PIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int FRAME_BYTES  = TOTAL_PIX / 8;
  localparam int PIX_W        = (TOTAL_PIX > 1) ? $clog2(TOTAL_PIX) : 1;
  localparam int BCNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int FIFO_ENTRIES = 1 << FIFO_DEPTH;

  localparam logic [PIX_W-1:0]      LAST_PIX  = PIX_W'(TOTAL_PIX - 1);
  localparam logic [BCNT_W-1:0]     LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);
  localparam logic [FIFO_DEPTH:0]   FULL_CNT  = (FIFO_DEPTH + 1)'(FIFO_ENTRIES);

`ifdef PACK_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
  logic [6:0]              shift_q, shift_d;
  logic [FIFO_DEPTH:0]     wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH:0]     rd_ptr_q, rd_ptr_d;
  logic [BCNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                    o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
  logic                    o_hdr_q, o_hdr_d;
  logic                    overflow_q, overflow_d;

  // Each FIFO word carries a header tag so frame counting skips sync bytes.
  logic [DATA_WIDTH:0]     fifo_mem [0:FIFO_ENTRIES-1];
  logic [DATA_WIDTH:0]     push_word;
  logic [DATA_WIDTH:0]     rd_word;
  logic [FIFO_DEPTH:0]     mem_cnt;
  logic [FIFO_DEPTH:0]     held;
  logic                    pix_bit;
  logic                    push;
  logic                    push_ok;
  logic                    pop;
  logic                    load;
  logic                    full;

  assign rd_word = fifo_mem[rd_ptr_q[FIFO_DEPTH-1:0]];
  assign mem_cnt = wr_ptr_q - rd_ptr_q;
  // Capacity counts the output register, so the bytes held never exceed FIFO_ENTRIES.
  assign held    = mem_cnt + {{FIFO_DEPTH{1'b0}}, o_valid_q};
  assign full    = (held == FULL_CNT);
  assign pop     = o_valid_q && i_ready;
  assign pix_bit = |canny_data;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_word  = '0;

    if (canny_de) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {shift_q[5:0], pix_bit};
      pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PIX_W'(1);
      if (bit_cnt_q == 3'd7) begin
        push      = 1'b1;
        push_word = {1'b0, DATA_WIDTH'({shift_q, pix_bit})};
      end
    end

    // A frame has at least 8 pixels, so header pushes never collide with a data push.
    case (state_q)
      IDLE: if (canny_de) state_d = HDR_EN ? HDR0 : DATA;
      HDR0: begin
        push      = 1'b1;
        push_word = {1'b1, DATA_WIDTH'(8'hA5)};
        state_d   = HDR1;
      end
      HDR1: begin
        push      = 1'b1;
        push_word = {1'b1, DATA_WIDTH'(8'h5A)};
        state_d   = DATA;
      end
      DATA: if (canny_de && pix_cnt_q == LAST_PIX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = wr_ptr_q + {{FIFO_DEPTH{1'b0}}, push_ok};
    load       = (mem_cnt != '0) && (!o_valid_q || pop);
    rd_ptr_d   = rd_ptr_q + {{FIFO_DEPTH{1'b0}}, load};
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_hdr_d    = o_hdr_q;
    if (load) begin
      o_valid_d = 1'b1;
      o_data_d  = rd_word[DATA_WIDTH-1:0];
      o_hdr_d   = rd_word[DATA_WIDTH];
    end else if (pop) begin
      o_valid_d = 1'b0;
    end
    byte_cnt_d = byte_cnt_q;
    if (pop && !o_hdr_q)
      byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BCNT_W'(1);
  end

  assign frame_done = pop && !o_hdr_q && (byte_cnt_q == LAST_BYTE);
  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[FIFO_DEPTH-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_hdr_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_hdr_q    <= o_hdr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
